// File: rtl/mfp_ahb_arbiter_pkg.sv
// Shared AHB-Lite encodings and the address-phase bundle used by the two-master arbiter.
package mfp_ahb_arbiter_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;

  typedef struct packed {
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic        hmastlock;
  } ahb_addr_t;

  function automatic logic is_burst4(input logic [2:0] b);
    return (b == HBURST_INCR4) || (b == HBURST_WRAP4);
  endfunction
endpackage

// File: rtl/mfp_ahb_arbiter_if.sv
// One AHB-Lite link; the arbiter faces each master through .slave and the fabric through .master.
interface mfp_ahb_arbiter_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK, HWDATA,
                  input  HREADY, HRESP, HRDATA);
  modport slave  (input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK, HWDATA,
                  output HREADY, HRESP, HRDATA);
endinterface

// File: rtl/mfp_ahb_arb_input_stage.sv
// Per-master holding register: parks an address phase the slave could not take yet.
module mfp_ahb_arb_input_stage
  import mfp_ahb_arbiter_pkg::*;
(
  input  logic      gclk,
  input  logic      grst_n,
  input  ahb_addr_t live,
  input  logic      capture,
  input  logic      issue,
  output logic      pend,
  output ahb_addr_t sel
);
  ahb_addr_t hold;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      pend <= 1'b0;
      hold <= '0;
    end else if (capture) begin
      pend <= 1'b1;
      hold <= live;
    end else if (issue) begin
      pend <= 1'b0;
    end
  end

  assign sel = pend ? hold : live;
endmodule

// File: rtl/mfp_ahb_arbiter.sv
// Two-master AHB-Lite arbiter: round-robin address grant, burst/lock hold, data phase routed to its owner.
module mfp_ahb_arbiter
  import mfp_ahb_arbiter_pkg::*;
(
  input  logic                HCLK,
  input  logic                HRESETn,
  mfp_ahb_arbiter_if.slave    m0,
  mfp_ahb_arbiter_if.slave    m1,
  mfp_ahb_arbiter_if.master   s
);
  ahb_addr_t   live0, live1, sel0, sel1, slv;
  logic        pend0, pend1, cap0, cap1, iss0, iss1, rdy0, rdy1;
  logic        owner, owner_nxt, last, last_nxt, dvalid, downer, lock_r, lock_nxt;
  logic [1:0]  beats_left, beats_nxt, s_htrans;
  logic        s_acc, hold, req0, req1;

  assign live0 = {m0.HADDR, m0.HTRANS, m0.HWRITE, m0.HSIZE, m0.HBURST, m0.HMASTLOCK};
  assign live1 = {m1.HADDR, m1.HTRANS, m1.HWRITE, m1.HSIZE, m1.HBURST, m1.HMASTLOCK};

  assign rdy0 = (dvalid && !downer) ? s.HREADY : !pend0;
  assign rdy1 = (dvalid &&  downer) ? s.HREADY : !pend1;

  // A master-accepted transfer bypasses the holding register only as the unblocked owner.
  assign cap0 = live0.htrans[1] && rdy0 && !(!owner && !pend0 && s.HREADY);
  assign cap1 = live1.htrans[1] && rdy1 && !( owner && !pend1 && s.HREADY);

  assign slv      = owner ? sel1 : sel0;
  assign s_htrans = HRESETn ? slv.htrans : HTRANS_IDLE;
  assign s_acc    = s.HREADY && s_htrans[1];
  assign iss0     = s_acc && !owner;
  assign iss1     = s_acc &&  owner;

  mfp_ahb_arb_input_stage u_in0 (.gclk(HCLK), .grst_n(HRESETn), .live(live0),
                                 .capture(cap0), .issue(iss0), .pend(pend0), .sel(sel0));
  mfp_ahb_arb_input_stage u_in1 (.gclk(HCLK), .grst_n(HRESETn), .live(live1),
                                 .capture(cap1), .issue(iss1), .pend(pend1), .sel(sel1));

  assign s.HADDR     = slv.haddr;
  assign s.HTRANS    = s_htrans;
  assign s.HWRITE    = slv.hwrite;
  assign s.HSIZE     = slv.hsize;
  assign s.HBURST    = slv.hburst;
  assign s.HMASTLOCK = slv.hmastlock;
  assign s.HWDATA    = downer ? m1.HWDATA : m0.HWDATA;

  assign m0.HREADY = rdy0;
  assign m1.HREADY = rdy1;
  assign m0.HRESP  = dvalid && !downer && s.HRESP;
  assign m1.HRESP  = dvalid &&  downer && s.HRESP;
  assign m0.HRDATA = s.HRDATA;
  assign m1.HRDATA = s.HRDATA;

  // Hold looks at the post-update counter so a burst's first beat holds and its last beat releases.
  always_comb begin
    beats_nxt = beats_left;
    lock_nxt  = lock_r;
    if (s.HREADY) begin
      if (s_acc) begin
        lock_nxt = slv.hmastlock;
        if (s_htrans == HTRANS_NONSEQ)
          beats_nxt = is_burst4(slv.hburst) ? 2'd3 : 2'd0;
        else if (s_htrans == HTRANS_SEQ && beats_left != 2'd0)
          beats_nxt = beats_left - 2'd1;
      end else begin
        lock_nxt = 1'b0;
      end
    end
  end

  assign hold = (beats_nxt != 2'd0) || lock_nxt;
  assign req0 = pend0 || (live0.htrans == HTRANS_NONSEQ);
  assign req1 = pend1 || (live1.htrans == HTRANS_NONSEQ);

  always_comb begin
    owner_nxt = owner;
    last_nxt  = last;
    if (s.HREADY && !hold && (req0 || req1)) begin
      owner_nxt = (req0 && req1) ? !last : req1;
      last_nxt  = owner_nxt;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      owner      <= 1'b0;
      last       <= 1'b1;
      dvalid     <= 1'b0;
      downer     <= 1'b0;
      lock_r     <= 1'b0;
      beats_left <= 2'd0;
    end else begin
      owner      <= owner_nxt;
      last       <= last_nxt;
      lock_r     <= lock_nxt;
      beats_left <= beats_nxt;
      if (s.HREADY) begin
        dvalid <= s_htrans[1];
        if (s_htrans[1]) downer <= owner;
      end
    end
  end
endmodule
